// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the ALU_System datapath.
// Optional single-step gate on instruction fetch: define CU_SINGLE_STEP_EN.
//
// state | meaning
// S_RST | clear RF and ARF for RST_CLR_CYCLES cycles
// S_FL  | fetch low byte of instruction, PC++
// S_FH  | fetch high byte of instruction, PC++
// S_EX  | execute opcode in IR[15:12]
// S_HLT | halted until reset
module control_sequencer #(
  parameter int unsigned RST_CLR_CYCLES = 1
) (
  input  logic       Clock,
  input  logic       Reset_N,
  input  logic [7:0] IR_High,
  input  logic [3:0] ALU_ZCNO,
`ifdef CU_SINGLE_STEP_EN
  input  logic       Step,
`endif
  output logic [1:0] MuxASel,
  output logic [1:0] MuxBSel,
  output logic       MuxCSel,
  output logic [2:0] RF_OutASel,
  output logic [2:0] RF_OutBSel,
  output logic [1:0] RF_FunSel,
  output logic [3:0] RF_TSel,
  output logic [3:0] RF_RSel,
  output logic [3:0] ALU_FunSel,
  output logic [1:0] ARF_OutASel,
  output logic [1:0] ARF_OutBSel,
  output logic [1:0] ARF_FunSel,
  output logic [3:0] ARF_RSel,
  output logic [1:0] IR_Funsel,
  output logic       IR_Enable,
  output logic       IR_LH,
  output logic       Mem_WR,
  output logic       Mem_CS,
  output logic       Halted
);

  typedef enum logic [2:0] {S_RST, S_FL, S_FH, S_EX, S_HLT} state_t;

  localparam logic [1:0] RST_LAST = 2'(RST_CLR_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       step_ok;
  logic [3:0] opcode;
  logic [1:0] rd, rs;
  logic [3:0] rd_onehot;
  logic       zero_flag;
  logic       unused_flags;

`ifdef CU_SINGLE_STEP_EN
  assign step_ok = Step;
`else
  assign step_ok = 1'b1;
`endif

  assign opcode       = IR_High[7:4];
  assign rd           = IR_High[3:2];
  assign rs           = IR_High[1:0];
  assign rd_onehot    = 4'b1000 >> rd;
  assign zero_flag    = ALU_ZCNO[3];
  assign unused_flags = ^ALU_ZCNO[2:0];

  always_ff @(posedge Clock) begin
    if (!Reset_N) begin
      state_q <= S_RST;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_FL;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_FL:    if (step_ok) state_d = S_FH;
      S_FH:    state_d = S_EX;
      S_EX:    state_d = (opcode == 4'hF) ? S_HLT : S_FL;
      S_HLT:   state_d = S_HLT;
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 1'b0;
    RF_OutASel  = 3'b000;
    RF_OutBSel  = 3'b000;
    RF_FunSel   = 2'b10;
    RF_TSel     = 4'b0000;
    RF_RSel     = 4'b0000;
    ALU_FunSel  = 4'b0000;
    ARF_OutASel = 2'b00;
    ARF_OutBSel = 2'b00;
    ARF_FunSel  = 2'b10;
    ARF_RSel    = 4'b0000;
    IR_Funsel   = 2'b10;
    IR_Enable   = 1'b0;
    IR_LH       = 1'b0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    Halted      = 1'b0;
    case (state_q)
      S_RST: begin
        RF_FunSel  = 2'b11;
        RF_RSel    = 4'b1111;
        RF_TSel    = 4'b1111;
        ARF_FunSel = 2'b11;
        ARF_RSel   = 4'b1110;
      end
      S_FL, S_FH: begin
        // a stalled single-step fetch keeps the bus idle
        if (state_q == S_FH || step_ok) begin
          Mem_CS     = 1'b0;
          IR_Enable  = 1'b1;
          IR_LH      = (state_q == S_FH);
          ARF_FunSel = 2'b01;
          ARF_RSel   = 4'b1000;
        end
      end
      S_EX: begin
        case (opcode)
          4'h1: begin
            MuxASel = 2'b10;
            RF_RSel = rd_onehot;
          end
          4'h2: begin
            ARF_OutBSel = 2'b01;
            Mem_CS      = 1'b0;
            MuxASel     = 2'b01;
            RF_RSel     = rd_onehot;
          end
          4'h3: begin
            RF_OutBSel  = {1'b1, rs};
            ALU_FunSel  = 4'b0001;
            ARF_OutBSel = 2'b01;
            Mem_CS      = 1'b0;
            Mem_WR      = 1'b1;
          end
          4'h4: begin
            RF_OutBSel = {1'b1, rs};
            ALU_FunSel = 4'b0001;
            RF_RSel    = rd_onehot;
          end
          4'h5, 4'h6, 4'h7: begin
            RF_OutASel = {1'b1, rd};
            RF_OutBSel = {1'b1, rs};
            ALU_FunSel = (opcode == 4'h5) ? 4'b0100 :
                         (opcode == 4'h6) ? 4'b0110 : 4'b0111;
            RF_RSel    = rd_onehot;
          end
          4'h8: begin
            MuxBSel  = 2'b10;
            ARF_RSel = 4'b0100;
          end
          4'h9, 4'hA: begin
            if (opcode == 4'h9 || !zero_flag) begin
              MuxBSel  = 2'b10;
              ARF_RSel = 4'b1000;
            end
          end
          default: ;
        endcase
      end
      S_HLT:   Halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Closed-loop bench: a behavioural ALU_System model is driven by the sequencer
// and its architectural state is compared with an instruction-level model.
module tb_control_sequencer;

  logic       Clock = 1'b0;
  logic       Reset_N = 1'b0;
`ifdef CU_SINGLE_STEP_EN
  logic       Step = 1'b1;
`endif
  logic [7:0] IR_High;
  logic [3:0] ALU_ZCNO;
  logic [1:0] MuxASel, MuxBSel, RF_FunSel, ARF_OutASel, ARF_OutBSel, ARF_FunSel, IR_Funsel;
  logic       MuxCSel, IR_Enable, IR_LH, Mem_WR, Mem_CS, Halted;
  logic [2:0] RF_OutASel, RF_OutBSel;
  logic [3:0] RF_TSel, RF_RSel, ALU_FunSel, ARF_RSel;

  always #5 Clock = ~Clock;

  control_sequencer dut (
    .Clock(Clock), .Reset_N(Reset_N), .IR_High(IR_High), .ALU_ZCNO(ALU_ZCNO),
`ifdef CU_SINGLE_STEP_EN
    .Step(Step),
`endif
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_TSel(RF_TSel), .RF_RSel(RF_RSel), .ALU_FunSel(ALU_FunSel),
    .ARF_OutASel(ARF_OutASel), .ARF_OutBSel(ARF_OutBSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RSel(ARF_RSel), .IR_Funsel(IR_Funsel), .IR_Enable(IR_Enable), .IR_LH(IR_LH),
    .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .Halted(Halted)
  );

  // datapath environment
  logic [7:0]  img [256];
  logic [7:0]  dp_mem [256];
  logic [7:0]  dp_r [4];
  logic [7:0]  dp_pc, dp_ar, dp_sp;
  logic [15:0] ir;
  logic        dp_z;
  logic [7:0]  rf_a, rf_b, arf_a, arf_b, alu_a, alu_out, mem_out, muxa, muxb;

  assign IR_High  = ir[15:8];
  assign ALU_ZCNO = {dp_z, 3'b000};

  always_comb begin
    rf_a = RF_OutASel[2] ? dp_r[RF_OutASel[1:0]] : 8'h00;
    rf_b = RF_OutBSel[2] ? dp_r[RF_OutBSel[1:0]] : 8'h00;
    case (ARF_OutASel)
      2'b00: arf_a = dp_pc;
      2'b01: arf_a = dp_ar;
      2'b10: arf_a = dp_sp;
      default: arf_a = 8'h00;
    endcase
    case (ARF_OutBSel)
      2'b00: arf_b = dp_pc;
      2'b01: arf_b = dp_ar;
      2'b10: arf_b = dp_sp;
      default: arf_b = 8'h00;
    endcase
    alu_a = MuxCSel ? arf_a : rf_a;
    case (ALU_FunSel)
      4'b0001: alu_out = rf_b;
      4'b0100: alu_out = alu_a + rf_b;
      4'b0110: alu_out = alu_a - rf_b;
      4'b0111: alu_out = alu_a & rf_b;
      default: alu_out = alu_a;
    endcase
    mem_out = dp_mem[arf_b];
    case (MuxASel)
      2'b00: muxa = alu_out;
      2'b01: muxa = mem_out;
      2'b10: muxa = ir[7:0];
      default: muxa = arf_a;
    endcase
    case (MuxBSel)
      2'b10: muxb = ir[7:0];
      2'b01: muxb = mem_out;
      default: muxb = alu_out;
    endcase
  end

  function automatic logic [7:0] apply_fun(input logic [1:0] f, input logic [7:0] cur,
                                           input logic [7:0] ld);
    case (f)
      2'b00: return cur - 8'd1;
      2'b01: return cur + 8'd1;
      2'b10: return ld;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge Clock) begin
    if (!Reset_N) begin
      for (int i = 0; i < 256; i++) dp_mem[i] <= img[i];
      dp_z <= 1'b0;
    end else begin
      if (!Mem_CS && Mem_WR) dp_mem[arf_b] <= alu_out;
      if (IR_Enable) begin
        if (IR_LH) ir[15:8] <= mem_out;
        else       ir[7:0]  <= mem_out;
      end
      for (int i = 0; i < 4; i++)
        if (RF_RSel[3-i]) dp_r[i] <= apply_fun(RF_FunSel, dp_r[i], muxa);
      if (ARF_RSel[3]) dp_pc <= apply_fun(ARF_FunSel, dp_pc, muxb);
      if (ARF_RSel[2]) dp_ar <= apply_fun(ARF_FunSel, dp_ar, muxb);
      if (ARF_RSel[1]) dp_sp <= apply_fun(ARF_FunSel, dp_sp, muxb);
      if (ALU_FunSel == 4'b0100 || ALU_FunSel == 4'b0110 || ALU_FunSel == 4'b0111)
        dp_z <= (alu_out == 8'h00);
    end
  end

  // instruction-level reference
  logic [7:0] ref_mem [256];
  logic [7:0] ref_r [4];
  logic [7:0] ref_pc, ref_ar;
  logic       ref_z, ref_halt;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic clear_image();
    for (int i = 0; i < 256; i++) begin
      img[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
  endtask

  task automatic set_byte(input logic [7:0] a, input logic [7:0] v);
    img[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic fill_random();
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom_range(0, 255));
      if (v[7:4] == 4'hF) v = v ^ 8'h80;
      img[i] = v;
      ref_mem[i] = v;
    end
  endtask

  task automatic do_reset();
    Reset_N = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check_val("rst_rf_fun", RF_FunSel, 2'b11);
    check_val("rst_rf_rsel", RF_RSel, 4'hF);
    check_val("rst_rf_tsel", RF_TSel, 4'hF);
    check_val("rst_arf_fun", ARF_FunSel, 2'b11);
    check_val("rst_arf_rsel", ARF_RSel, 4'hE);
    check_val("rst_mem_cs", Mem_CS, 1'b1);
    check_val("rst_halted", Halted, 1'b0);
    Reset_N = 1'b1;
    @(posedge Clock);
    #1;
    for (int i = 0; i < 4; i++) ref_r[i] = 8'h00;
    ref_pc = 8'h00; ref_ar = 8'h00; ref_z = 1'b0; ref_halt = 1'b0;
    check_val("fl_arf_outb", ARF_OutBSel, 2'b00);
    check_val("fl_mem_cs", Mem_CS, 1'b0);
    check_val("fl_ir_lh", IR_LH, 1'b0);
    check_val("fl_ir_en", IR_Enable, 1'b1);
    check_val("fl_pc_inc", {ARF_FunSel, ARF_RSel}, {2'b01, 4'b1000});
    check_val("clr_pc", dp_pc, 8'h00);
    check_val("clr_regs", {dp_r[0], dp_r[1], dp_r[2], dp_r[3]} == 32'h0, 1'b1);
  endtask

  task automatic step_instr();
    logic [7:0] lo, hi, res;
    logic [3:0] op;
    logic [1:0] rd, rs;
    lo = ref_mem[ref_pc];
    hi = ref_mem[8'(ref_pc + 8'd1)];
    ref_pc = ref_pc + 8'd2;
    op = hi[7:4]; rd = hi[3:2]; rs = hi[1:0];
    res = 8'h00;
    case (op)
      4'h1: ref_r[rd] = lo;
      4'h2: ref_r[rd] = ref_mem[ref_ar];
      4'h3: ref_mem[ref_ar] = ref_r[rs];
      4'h4: ref_r[rd] = ref_r[rs];
      4'h5, 4'h6, 4'h7: begin
        res = (op == 4'h5) ? ref_r[rd] + ref_r[rs] :
              (op == 4'h6) ? ref_r[rd] - ref_r[rs] : ref_r[rd] & ref_r[rs];
        ref_r[rd] = res;
        ref_z = (res == 8'h00);
      end
      4'h8: ref_ar = lo;
      4'h9: ref_pc = lo;
      4'hA: if (!ref_z) ref_pc = lo;
      4'hF: ref_halt = 1'b1;
      default: ;
    endcase
    repeat (2) @(posedge Clock);
    #1;
    check_val("ex_mem_wr", Mem_WR, op == 4'h3);
    check_val("ex_arf_outb", ARF_OutBSel, (op == 4'h2 || op == 4'h3) ? 2'b01 : 2'b00);
    check_val("ex_halted", Halted, 1'b0);
    @(posedge Clock);
    #1;
    check_val("pc", dp_pc, ref_pc);
    check_val("ar", dp_ar, ref_ar);
    for (int i = 0; i < 4; i++) check_val($sformatf("r%0d", i + 1), dp_r[i], ref_r[i]);
    check_val("zflag", dp_z, ref_z);
    check_val("halted", Halted, ref_halt);
    if (op == 4'h3) check_val("stm_mem", dp_mem[ref_ar], ref_mem[ref_ar]);
  endtask

  initial begin
    clear_image();
    set_byte(8'h00, 8'h2A); set_byte(8'h01, 8'h14);
    do_reset();
    step_instr();
    check_val("ldi_r2", dp_r[1], 8'h2A);
    check_val("ldi_pc", dp_pc, 8'h02);

    clear_image();
    set_byte(8'h00, 8'h05); set_byte(8'h01, 8'h10);
    set_byte(8'h02, 8'h05); set_byte(8'h03, 8'h14);
    set_byte(8'h04, 8'h00); set_byte(8'h05, 8'h61);
    set_byte(8'h06, 8'h40); set_byte(8'h07, 8'hA0);
    set_byte(8'h08, 8'h00); set_byte(8'h09, 8'h51);
    set_byte(8'h0A, 8'h40); set_byte(8'h0B, 8'hA0);
    do_reset();
    repeat (4) step_instr();
    check_val("bne_not_taken_pc", dp_pc, 8'h08);
    repeat (2) step_instr();
    check_val("bne_taken_pc", dp_pc, 8'h40);
    check_val("add_r1", dp_r[0], 8'h05);

    clear_image();
    set_byte(8'h00, 8'h80); set_byte(8'h01, 8'h80);
    set_byte(8'h02, 8'h77); set_byte(8'h03, 8'h18);
    set_byte(8'h04, 8'h00); set_byte(8'h05, 8'h32);
    do_reset();
    repeat (3) step_instr();
    check_val("stm_mem80", dp_mem[8'h80], 8'h77);

    clear_image();
    set_byte(8'h01, 8'hF0);
    do_reset();
    step_instr();
    for (int i = 0; i < 20; i++) begin
      @(posedge Clock);
      #1;
      check_val("hlt_halted", Halted, 1'b1);
      check_val("hlt_mem_cs", Mem_CS, 1'b1);
    end
    check_val("hlt_pc", dp_pc, 8'h02);
    do_reset();
    check_val("post_hlt_halted", Halted, 1'b0);

    for (int p = 0; p < 3; p++) begin
      fill_random();
      do_reset();
      repeat (40) step_instr();
    end

`ifdef CU_SINGLE_STEP_EN
    clear_image();
    set_byte(8'h00, 8'h33); set_byte(8'h01, 8'h10);
    set_byte(8'h02, 8'h44); set_byte(8'h03, 8'h14);
    do_reset();
    Step = 1'b0;
    #1;
    check_val("step_idle_cs", Mem_CS, 1'b1);
    check_val("step_idle_ir_en", IR_Enable, 1'b0);
    repeat (10) @(posedge Clock);
    #1;
    check_val("step_hold_pc", dp_pc, 8'h00);
    check_val("step_hold_cs", Mem_CS, 1'b1);
    Step = 1'b1;
    @(posedge Clock);
    #1;
    Step = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check_val("step_r1", dp_r[0], 8'h33);
    check_val("step_pc", dp_pc, 8'h02);
    repeat (5) @(posedge Clock);
    #1;
    check_val("step_pc_held", dp_pc, 8'h02);
    check_val("step_r2_untouched", dp_r[1], 8'h00);
    Step = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives every control input of the ALU_System datapath.
- Fetches a 16-bit instruction from memory into the IR, low byte first.
- Decodes IR[15:8] (datapath `out`) and issues one execute cycle per instruction.
- Sits directly upstream of ALU_System; its outputs connect one-to-one to the like-named ALU_System inputs.

Parameters:
- RST_CLR_CYCLES, 1, number of cycles spent in S_RST clearing RF and ARF after reset release (1..3).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_N  in  1  synchronous, active-low reset.
- IR_High  in  8  IR[15:8] from ALU_System `out`; [7:4] opcode, [3:2] Rd, [1:0] Rs.
- ALU_ZCNO  in  4  ALU flags; bit3 = Z.
- MuxASel, MuxBSel  out  2 each  datapath muxes.
- MuxCSel  out  1  datapath mux.
- RF_OutASel, RF_OutBSel  out  3 each  RF read selects.
- RF_FunSel  out  2  RF function.
- RF_TSel, RF_RSel  out  4 each  RF enables.
- ALU_FunSel  out  4  ALU function.
- ARF_OutASel, ARF_OutBSel, ARF_FunSel  out  2 each  ARF selects/function.
- ARF_RSel  out  4  ARF enables.
- IR_Funsel  out  2  IR function.
- IR_Enable, IR_LH  out  1 each  IR controls.
- Mem_WR, Mem_CS  out  1 each  memory controls.
- Halted  out  1  high while in S_HLT.

Behaviour:
- Reset is synchronous and active-low: while Reset_N=0 at a rising Clock edge, state <= S_RST and the cycle counter <= 0.
- Outputs are combinational decode of the state register plus IR_High.
- Idle defaults, applied in every cycle unless overridden:
  - all RSel/TSel = 0000; IR_Enable=0.
  - Mem_CS=1 (disabled); Mem_WR=0.
  - FunSels=10; mux selects 0; out-selects 0.
  - Halted=0.
- Encodings:
  - FunSel: 00 dec, 01 inc, 10 load, 11 clear.
  - RF RSel one-hot: bit3=R1 .. bit0=R4. Register n (0..3) is read with OutSel = {1'b1, n}.
  - ARF: OutSel 00=PC, 01=AR, 10=SP; RSel bit3=PC, bit2=AR, bit1=SP.
  - ALU: 0001 pass B, 0100 A+B, 0110 A-B, 0111 A AND B.
  - Mem_CS active-low; Mem_WR=1 writes.
  - IR_LH: 0 loads the low byte, 1 loads the high byte.
- States: S_RST, S_FL, S_FH, S_EX, S_HLT.
- S_RST:
  - Drives RF_FunSel=11, RF_RSel=1111, RF_TSel=1111, ARF_FunSel=11, ARF_RSel=1110.
  - Held for RST_CLR_CYCLES cycles, then goes to S_FL.
- S_FL:
  - ARF_OutBSel=00, Mem_CS=0, IR_Enable=1, IR_LH=0.
  - ARF_FunSel=01, ARF_RSel=1000 (PC++).
  - Next state S_FH.
- S_FH: same as S_FL with IR_LH=1; next state S_EX.
- S_EX executes one opcode, then goes to S_FL (S_HLT for opcode F):
  - 0 NOP: idle defaults only.
  - 1 LDI: MuxASel=10, RF_RSel=onehot(Rd).
  - 2 LDM: ARF_OutBSel=01, Mem_CS=0, MuxASel=01, RSel=Rd.
  - 3 STM: RF_OutBSel=Rs, ALU=0001, ARF_OutBSel=01, Mem_CS=0, Mem_WR=1.
  - 4 MOV: RF_OutBSel=Rs, ALU=0001, MuxASel=00, RSel=Rd.
  - 5 ADD / 6 SUB / 7 AND: RF_OutASel=Rd, MuxCSel=0, RF_OutBSel=Rs, ALU 0100/0110/0111, MuxASel=00, RSel=Rd.
  - 8 LAR: MuxBSel=10, ARF_RSel=0100.
  - 9 BRA: MuxBSel=10, ARF_RSel=1000.
  - A BNE: same as BRA only when ALU_ZCNO[3]=0; otherwise idle defaults.
  - F HLT: next state S_HLT.
  - B-E: treated as NOP.
- S_HLT: idle defaults with Halted=1; leaves only on reset.
- Timing:
  - Every instruction takes exactly 3 cycles.
  - PC advances by 2 per fetch.
  - PC wraps 0xFF -> 0x00 without special handling.
- BNE tests the flags registered by the most recent ALU op.
- Reset asserted in any state, including mid-fetch: next state is S_RST; IR contents are don't-care until the next S_FH completes.

Optional Feature:
- Macro CU_SINGLE_STEP_EN.
- When defined:
  - Adds input Step (1 bit).
  - S_FL outputs are held at idle defaults and the state stays in S_FL until a cycle with Step=1; that cycle performs the normal S_FL actions.
  - Step is sampled only in S_FL.
- When undefined: port Step is absent and S_FL always advances.

Test Plan:
- Reset_N low 2 cycles then high -> S_RST clear drives observed for 1 cycle; PC=0; first S_FL shows ARF_OutBSel=00, Mem_CS=0, IR_LH=0.
- Memory [0]=0x2A, [1]=0x14 (LDI R2,0x2A) -> after 3 cycles R2=0x2A and PC=2.
- LDI R1,5; LDI R2,5; SUB R1,R2; BNE 0x40 -> Z=1 so the branch is not taken and PC=8. Then ADD R1,R2 (R1=5); BNE 0x40 -> PC=0x40.
- LAR 0x80; LDI R3,0x77; STM R3 -> Mem_WR=1 with ARF_OutBSel=01 in S_EX; mem[0x80]=0x77.
- HLT (0xF0) -> Halted=1 held for 20 cycles, Mem_CS=1 throughout; Reset_N pulse returns to S_RST.
- With CU_SINGLE_STEP_EN: Step=0 for 10 cycles -> PC unchanged; one Step pulse -> exactly one instruction executes.
